digit_scan_counter: RTL and testbench
=====================================

// Module: digit_scan_counter
// PURPOSE
//  Parametrised multiplexed-display scan sequencer; drives digit select for the 7-seg mux path.
//  Cycles through NUM_DIGITS digits, skipping digits masked off.
//  Per-digit dwell time and an optional dead-time (anti-ghosting) gap between digits.
//  Default parameters reproduce the plain 2-bit 0,1,2,3,0 scan sequence cycle-for-cycle.
// PARAMETERS
//  NUM_DIGITS   4  number of display digits; legal range >=1.
//  DWELL_TICKS  1  clock cycles each digit is lit; legal range >=1.
//  BLANK_TICKS  0  dead-time cycles with no digit lit between digits; 0 means no gap.
//  Derived: CNT_W = max(1,$clog2(NUM_DIGITS)); TICK_W = $clog2(max(DWELL_TICKS,BLANK_TICKS)+1).
//  Illegal values raise an elaboration-time $error.
// PORTS
//  clock_1KHz    in   1           scan clock; single clock domain.
//  reset_n       in   1           asynchronous, active-low reset.
//  enable        in   1           1=advance; 0=freeze all state and outputs.
//  digit_mask    in   NUM_DIGITS  bit i=1: digit i takes part in the scan.
//  digitCount    out  CNT_W       index of current/last lit digit.
//  anode_onehot  out  NUM_DIGITS  active-high one-hot of lit digit; all 0 when none is lit.
//  blanking      out  1           1 when no digit is lit (IDLE or BLANK).
//  frame_start   out  1           one-cycle pulse when a new scan frame begins.
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=S_IDLE, digitCount=0, anode_onehot=0, blanking=1, frame_start=0, tick=0.
//  Outputs:
//   - All outputs are registered.
//   - anode_onehot = (1<<digitCount) in S_SHOW, else 0.
//   - blanking = (state!=S_SHOW).
//  enable=0:
//   - state, tick counter and all outputs hold.
//   - frame_start is forced 0.
//  next(i):
//   - First index j in circular order i+1, i+2, ... (mod NUM_DIGITS), then i itself, with digit_mask[j]=1.
//   - Wrap goes from NUM_DIGITS-1 to 0, also for non-power-of-2 counts.
//   - From S_IDLE the search starts at index 0 (lowest set bit).
//  FSM (only evaluated when enable=1):
//   - S_IDLE:
//     - digit_mask==0: stay in S_IDLE.
//     - Otherwise: next cycle S_SHOW, digitCount=lowest set index, frame_start=1.
//   - S_SHOW:
//     - tick counts 0..DWELL_TICKS-1.
//     - At tick==DWELL_TICKS-1, or earlier if digit_mask[digitCount]==0 (early abort):
//       - digit_mask==0: go to S_IDLE.
//       - BLANK_TICKS>0: go to S_BLANK, tick=0, digitCount holds.
//       - BLANK_TICKS==0: stay in S_SHOW, digitCount=next(digitCount), tick=0.
//   - S_BLANK:
//     - Lasts BLANK_TICKS cycles.
//     - Then S_SHOW with digitCount=next(digitCount), using the mask sampled on that cycle.
//     - If digit_mask==0 on that cycle: go to S_IDLE.
//  frame_start:
//   - Pulses on the cycle a new digit is loaded with new index <= old index (wrap).
//   - Also pulses on the S_IDLE->S_SHOW transition.
//   - With a single enabled digit it pulses on every reload.
//  Boundary rules:
//   - NUM_DIGITS=1: digitCount is constant 0.
//   - Mask changes apply at the next digit selection, except the early-abort case above.
//   - reset_n asserted mid-dwell or mid-blank: immediate return to reset values.
//   - No tick counter overflow: tick is cleared on every state change.
// STRUCTURE
//  Package display_scan_pkg:
//   - typedef enum logic [1:0] {S_IDLE,S_SHOW,S_BLANK} scan_state_t.
//   - Function onehot_of(idx).
//  Sub-module next_digit_finder (#(NUM_DIGITS)):
//   - Purely combinational circular priority search.
//   - Inputs: mask, start index, from_idle flag.
//   - Outputs: next index, found flag, wrapped flag.
//  Top level: one always_ff for FSM, tick counter and output registers; async reset_n in sensitivity list.
// TESTING
//  1. Defaults, mask=4'hF, enable=1 for 8 clocks -> digitCount 0,1,2,3,0,1,2,3; frame_start on each 0.
//  2. NUM_DIGITS=6, DWELL=3, BLANK=2, mask=6'h3F:
//     - Each digit lit 3 clocks then anode=0 for 2 clocks.
//     - 5 wraps to 0.
//  3. NUM_DIGITS=4, mask=4'b1010 -> digitCount 1,3,1,3; anode_onehot 0010,1000.
//  4. mask->0 mid-scan -> S_IDLE within DWELL clocks, anode_onehot=0, blanking=1; mask->4'h4 -> digit 2 lit, frame_start=1.
//  5. enable=0 for 5 clocks mid-dwell -> outputs frozen; dwell resumes with the remaining ticks.
//  6. reset_n low mid-blank -> outputs at reset values immediately (async); scan restarts at lowest enabled digit.

Source files
------------

// File: rtl/display_scan_pkg.sv
// Shared state encoding and helpers for the multiplexed-display scan sequencer.
package display_scan_pkg;

    localparam int MAX_DIGITS = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_BLANK = 2'd2
    } scan_state_t;

    function automatic logic [MAX_DIGITS-1:0] onehot_of(input int idx);
        return MAX_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/next_digit_finder.sv
// Combinational circular priority search for the next enabled digit after start_idx_i
// (or the lowest enabled digit when leaving idle).
module next_digit_finder #(
    parameter int  NUM_DIGITS = 4,
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic [NUM_DIGITS-1:0] mask_i,
    input  logic [CNT_W-1:0]      start_idx_i,
    input  logic                  from_idle_i,
    output logic [CNT_W-1:0]      next_idx_o,
    output logic                  found_o,
    output logic                  wrapped_o
);

    logic [2*NUM_DIGITS-1:0] doubled;
    logic [NUM_DIGITS-1:0]   rotated;
    int                      base;
    int                      first;
    int                      offset;
    int                      target;

    // Rotate the mask so the search always begins at bit 0; leaving idle acts like
    // starting just after the last digit, which makes index 0 the first candidate.
    always_comb begin
        base    = from_idle_i ? NUM_DIGITS - 1 : int'(start_idx_i);
        first   = (base + 1) % NUM_DIGITS;
        doubled = {mask_i, mask_i};
        rotated = NUM_DIGITS'(doubled >> first);
        found_o = 1'b0;
        offset  = 0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found_o = 1'b1;
                offset  = k;
            end
        end
        target     = (first + offset) % NUM_DIGITS;
        next_idx_o = CNT_W'(target);
        wrapped_o  = from_idle_i || (target <= int'(start_idx_i));
    end

endmodule

// File: rtl/digit_scan_counter.sv
// Multiplexed-display scan sequencer: walks the enabled digits with a per-digit dwell
// time and an optional dead-time gap, producing registered digit-select outputs.
module digit_scan_counter
    import display_scan_pkg::*;
#(
    parameter int  NUM_DIGITS  = 4,
    parameter int  DWELL_TICKS = 1,
    parameter int  BLANK_TICKS = 0,
    localparam int CNT_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int TICK_W      = $clog2(((DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS) + 1)
) (
    input  logic                  clock_1KHz,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [CNT_W-1:0]      digitCount,
    output logic [NUM_DIGITS-1:0] anode_onehot,
    output logic                  blanking,
    output logic                  frame_start
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("digit_scan_counter: NUM_DIGITS must be in 1..%0d", MAX_DIGITS);
    end
    if (DWELL_TICKS < 1) begin : g_bad_dwell
        $error("digit_scan_counter: DWELL_TICKS must be >= 1");
    end
    if (BLANK_TICKS < 0) begin : g_bad_blank
        $error("digit_scan_counter: BLANK_TICKS must be >= 0");
    end

    localparam logic [TICK_W-1:0] DWELL_LAST = TICK_W'(DWELL_TICKS - 1);
    localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

    scan_state_t           state_q;
    logic [TICK_W-1:0]     tick_q;
    logic [CNT_W-1:0]      digit_count_q;
    logic [NUM_DIGITS-1:0] anode_q;
    logic                  blanking_q;
    logic                  frame_start_q;

    logic [CNT_W-1:0]      next_idx;
    logic                  next_found;
    logic                  next_wrapped;
    logic [NUM_DIGITS-1:0] next_onehot;
    logic                  cur_enabled;

    next_digit_finder #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_finder (
        .mask_i      (digit_mask),
        .start_idx_i (digit_count_q),
        .from_idle_i (state_q == S_IDLE),
        .next_idx_o  (next_idx),
        .found_o     (next_found),
        .wrapped_o   (next_wrapped)
    );

    assign next_onehot = NUM_DIGITS'(onehot_of(int'(next_idx)));
    // In S_SHOW the anode register is exactly the one-hot of the lit digit.
    assign cur_enabled = |(digit_mask & anode_q);

    always_ff @(posedge clock_1KHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            tick_q        <= '0;
            digit_count_q <= '0;
            anode_q       <= '0;
            blanking_q    <= 1'b1;
            frame_start_q <= 1'b0;
        end else if (!enable) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (next_found) begin
                        state_q       <= S_SHOW;
                        tick_q        <= '0;
                        digit_count_q <= next_idx;
                        anode_q       <= next_onehot;
                        blanking_q    <= 1'b0;
                        frame_start_q <= 1'b1;
                    end
                end
                S_SHOW: begin
                    // A digit masked off while lit is dropped without waiting out its dwell.
                    if (tick_q == DWELL_LAST || !cur_enabled) begin
                        tick_q <= '0;
                        if (!next_found) begin
                            state_q    <= S_IDLE;
                            anode_q    <= '0;
                            blanking_q <= 1'b1;
                        end else if (BLANK_TICKS > 0) begin
                            state_q    <= S_BLANK;
                            anode_q    <= '0;
                            blanking_q <= 1'b1;
                        end else begin
                            digit_count_q <= next_idx;
                            anode_q       <= next_onehot;
                            frame_start_q <= next_wrapped;
                        end
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end
                S_BLANK: begin
                    if (tick_q == BLANK_LAST) begin
                        tick_q <= '0;
                        if (!next_found) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q       <= S_SHOW;
                            digit_count_q <= next_idx;
                            anode_q       <= next_onehot;
                            blanking_q    <= 1'b0;
                            frame_start_q <= next_wrapped;
                        end
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    tick_q     <= '0;
                    anode_q    <= '0;
                    blanking_q <= 1'b1;
                end
            endcase
        end
    end

    assign digitCount   = digit_count_q;
    assign anode_onehot = anode_q;
    assign blanking     = blanking_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_digit_scan_counter.sv
// Scoreboard bench: a default-parameter scanner and a 6-digit scanner with dwell and
// dead-time, driven with directed vectors whose expected outputs are queued per cycle.
module tb_digit_scan_counter;

    typedef struct {
        int    dut;
        string name;
        int    cnt;
        int    anode;
        int    blank;
        int    frame;
    } exp_t;

    logic       clock_1KHz = 1'b0;

    logic       rstA;
    logic       enA;
    logic [3:0] maskA;
    logic [1:0] cntA;
    logic [3:0] anA;
    logic       blankA;
    logic       frameA;

    logic       rstB;
    logic       enB;
    logic [5:0] maskB;
    logic [2:0] cntB;
    logic [5:0] anB;
    logic       blankB;
    logic       frameB;

    exp_t expQ[$];
    int   passCount  = 0;
    int   checkCount = 0;
    event checkNow;

    int   altSeq[4]     = '{1, 3, 1, 3};
    int   resumeCnt[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
    int   resumeLit[8]  = '{1, 1, 0, 0, 1, 1, 1, 0};
    int   digitIdx;
    int   phase;

    always #5 clock_1KHz = ~clock_1KHz;

    digit_scan_counter dutA (
        .clock_1KHz   (clock_1KHz),
        .reset_n      (rstA),
        .enable       (enA),
        .digit_mask   (maskA),
        .digitCount   (cntA),
        .anode_onehot (anA),
        .blanking     (blankA),
        .frame_start  (frameA)
    );

    digit_scan_counter #(
        .NUM_DIGITS  (6),
        .DWELL_TICKS (3),
        .BLANK_TICKS (2)
    ) dutB (
        .clock_1KHz   (clock_1KHz),
        .reset_n      (rstB),
        .enable       (enB),
        .digit_mask   (maskB),
        .digitCount   (cntB),
        .anode_onehot (anB),
        .blanking     (blankB),
        .frame_start  (frameB)
    );

    task automatic applyStimulus(input int d, input logic en, input logic [5:0] mask);
        if (d == 0) begin
            enA   = en;
            maskA = mask[3:0];
        end else begin
            enB   = en;
            maskB = mask;
        end
    endtask

    task automatic expectOut(input int d, input string name, input int cnt, input int anode,
                             input int blank, input int frame);
        exp_t e;
        e.dut   = d;
        e.name  = name;
        e.cnt   = cnt;
        e.anode = anode;
        e.blank = blank;
        e.frame = frame;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every entry queued for this edge is compared just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock_1KHz or checkNow);
            #1;
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                if (e.dut == 0) begin
                    checkOutput($sformatf("%s.digitCount", e.name), int'(cntA), e.cnt);
                    checkOutput($sformatf("%s.anode", e.name), int'(anA), e.anode);
                    checkOutput($sformatf("%s.blanking", e.name), int'(blankA), e.blank);
                    checkOutput($sformatf("%s.frame_start", e.name), int'(frameA), e.frame);
                end else begin
                    checkOutput($sformatf("%s.digitCount", e.name), int'(cntB), e.cnt);
                    checkOutput($sformatf("%s.anode", e.name), int'(anB), e.anode);
                    checkOutput($sformatf("%s.blanking", e.name), int'(blankB), e.blank);
                    checkOutput($sformatf("%s.frame_start", e.name), int'(frameB), e.frame);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstA = 1'b0;
        rstB = 1'b0;
        applyStimulus(0, 1'b0, 6'h00);
        applyStimulus(1, 1'b0, 6'h00);

        @(negedge clock_1KHz);
        @(negedge clock_1KHz);
        expectOut(0, "resetA", 0, 0, 1, 0);
        expectOut(1, "resetB", 0, 0, 1, 0);

        @(negedge clock_1KHz);
        rstA = 1'b1;
        rstB = 1'b1;
        expectOut(0, "idleHoldA", 0, 0, 1, 0);
        expectOut(1, "idleHoldB", 0, 0, 1, 0);

        // Plain 4-digit scan
        for (int i = 0; i < 8; i++) begin
            @(negedge clock_1KHz);
            applyStimulus(0, 1'b1, 6'h0F);
            expectOut(0, $sformatf("scanA[%0d]", i), i % 4, 1 << (i % 4), 0, int'(i % 4 == 0));
        end

        // Alternate digits only
        for (int i = 0; i < 4; i++) begin
            @(negedge clock_1KHz);
            applyStimulus(0, 1'b1, 6'h0A);
            expectOut(0, $sformatf("altA[%0d]", i), altSeq[i], 1 << altSeq[i], 0, int'(i % 2 == 0));
        end

        // Mask cleared, then a single digit re-enabled
        @(negedge clock_1KHz);
        applyStimulus(0, 1'b1, 6'h00);
        expectOut(0, "maskOffA", 3, 0, 1, 0);
        @(negedge clock_1KHz);
        expectOut(0, "idleStayA", 3, 0, 1, 0);
        @(negedge clock_1KHz);
        applyStimulus(0, 1'b1, 6'h04);
        expectOut(0, "wakeA", 2, 4, 0, 1);
        @(negedge clock_1KHz);
        expectOut(0, "singleReloadA", 2, 4, 0, 1);
        @(negedge clock_1KHz);
        applyStimulus(0, 1'b0, 6'h04);
        expectOut(0, "freezeA", 2, 4, 0, 0);
        @(negedge clock_1KHz);
        expectOut(0, "freezeA2", 2, 4, 0, 0);

        // Six digits, 3-cycle dwell then 2-cycle gap, through one full wrap
        for (int c = 1; c <= 31; c++) begin
            @(negedge clock_1KHz);
            applyStimulus(1, 1'b1, 6'h3F);
            digitIdx = ((c - 1) / 5) % 6;
            phase    = (c - 1) % 5;
            expectOut(1, $sformatf("scanB[%0d]", c), digitIdx,
                      (phase < 3) ? (1 << digitIdx) : 0, int'(phase >= 3),
                      int'(phase == 0 && digitIdx == 0));
        end

        // Freeze at the first dwell cycle of digit 0
        for (int k = 0; k < 5; k++) begin
            @(negedge clock_1KHz);
            applyStimulus(1, 1'b0, 6'h3F);
            expectOut(1, $sformatf("freezeB[%0d]", k), 0, 1, 0, 0);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clock_1KHz);
            applyStimulus(1, 1'b1, 6'h3F);
            expectOut(1, $sformatf("resumeB[%0d]", k), resumeCnt[k],
                      (resumeLit[k] != 0) ? (1 << resumeCnt[k]) : 0, int'(resumeLit[k] == 0), 0);
        end

        // Asynchronous reset in the middle of digit 1's gap
        @(negedge clock_1KHz);
        applyStimulus(1, 1'b1, 6'h0C);
        rstB = 1'b0;
        expectOut(1, "asyncResetB", 0, 0, 1, 0);
        ->checkNow;
        #2;
        rstB = 1'b1;
        expectOut(1, "restartB", 2, 4, 0, 1);

        // Lit digit masked off mid-dwell
        @(negedge clock_1KHz);
        applyStimulus(1, 1'b1, 6'h08);
        expectOut(1, "earlyAbortB", 2, 0, 1, 0);
        @(negedge clock_1KHz);
        expectOut(1, "abortBlankB", 2, 0, 1, 0);
        @(negedge clock_1KHz);
        expectOut(1, "afterAbortB", 3, 8, 0, 0);
        @(negedge clock_1KHz);
        expectOut(1, "afterAbortB2", 3, 8, 0, 0);

        @(negedge clock_1KHz);
        @(negedge clock_1KHz);
        checkOutput("queueDrained", expQ.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
